// File: rtl/rtc_display_mux_if.sv
// Control, time and display-pin bundle of the RTC display mux.
// The master drives the user controls; the slave (the RTC) drives time and pins.
interface rtc_display_mux_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic                  run_en;
    logic [1:0]            set_mode;
    logic                  inc;
    logic                  clr_sec;
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [4:0]            hours;
    logic [5:0]            minutes;
    logic [5:0]            seconds;
    logic                  sec_tick;

    modport master (
        output run_en, set_mode, inc, clr_sec,
        input  seg, digit_sel, hours, minutes, seconds, sec_tick
    );

    modport slave (
        input  run_en, set_mode, inc, clr_sec,
        output seg, digit_sel, hours, minutes, seconds, sec_tick
    );
endinterface

// File: rtl/rtc_display_mux.sv
// HH:MM:SS real-time clock with run/pause, hour/minute set mode and a
// multiplexed 4- or 6-digit 7-segment driver; every output is registered.
module rtc_display_mux #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 6,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    rtc_display_mux_if.slave bus
);

    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned SW  = $clog2(SCAN_DIV);
    localparam int unsigned IW  = 3;
    localparam int unsigned DW  = NUM_DIGITS;
    localparam bit          SIX = (NUM_DIGITS == 6);

    localparam logic [7:0]    SEG_ZERO_AH = 8'h3F;
    localparam logic [7:0]    SEG_RST     = ACTIVE_LOW ? ~SEG_ZERO_AH : SEG_ZERO_AH;
    localparam logic [DW-1:0] DSEL_RST    = ACTIVE_LOW ? ~DW'(1) : DW'(1);

    if (!(NUM_DIGITS == 4 || NUM_DIGITS == 6)) begin : g_bad_num_digits
        $error("rtc_display_mux: NUM_DIGITS must be 4 or 6");
    end
    if (TICK_DIV < 4) begin : g_bad_tick_div
        $error("rtc_display_mux: TICK_DIV must be at least 4");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("rtc_display_mux: SCAN_DIV must be at least 2");
    end

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    mode_e          mode;
    logic [PW-1:0]  presc_q, presc_d;
    logic           sec_tick_q, sec_tick_d;
    logic [4:0]     hours_q, hours_d;
    logic [5:0]     minutes_q, minutes_d;
    logic [5:0]     seconds_q, seconds_d;
    logic [SW-1:0]  scan_q, scan_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     seg_q, seg_d;
    logic [DW-1:0]  dsel_q, dsel_d;

    logic           tick;
    logic           blink_on;
    logic           scan_wrap;
    logic [5:0]     hours6;
    logic [3:0]     sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic [IW-1:0]  pos;
    logic [3:0]     digit_val;
    logic           is_hr, is_min, dp_pos, blank;
    logic [7:0]     seg_ah;
    logic [DW-1:0]  dsel_ah;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    // Mode 11 behaves as run mode.
    always_comb begin
        mode = MODE_RUN;
        case (bus.set_mode)
            2'b01:   mode = MODE_SET_HR;
            2'b10:   mode = MODE_SET_MIN;
            default: mode = MODE_RUN;
        endcase
    end

    // Prescaler and timekeeping; clr_sec overrides a coincident tick and its carry.
    always_comb begin
        presc_d    = presc_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        tick       = bus.run_en && (presc_q == PW'(TICK_DIV - 1));
        sec_tick_d = tick;
        blink_on   = (presc_q < PW'(TICK_DIV / 2));

        if (bus.run_en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (bus.clr_sec) begin
            presc_d   = '0;
            seconds_d = '0;
        end else if (tick && mode == MODE_RUN) begin
            if (seconds_q == 6'd59) begin
                seconds_d = '0;
                if (minutes_q == 6'd59) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end

        if (bus.inc && mode == MODE_SET_HR) begin
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
        if (bus.inc && mode == MODE_SET_MIN) begin
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end
    end

    // Free-running scan divider and digit index.
    always_comb begin
        scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
        idx_d     = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        hours6   = {1'b0, hours_q};
        sec_ones = 4'(seconds_q % 6'd10);
        sec_tens = 4'(seconds_q / 6'd10);
        min_ones = 4'(minutes_q % 6'd10);
        min_tens = 4'(minutes_q / 6'd10);
        hr_ones  = 4'(hours6 % 6'd10);
        hr_tens  = 4'(hours6 / 6'd10);
    end

    // A 4-digit display is the 6-digit layout without the two seconds digits.
    always_comb begin
        digit_val = '0;
        is_hr     = 1'b0;
        is_min    = 1'b0;
        pos       = SIX ? idx_d : idx_d + IW'(2);
        case (pos)
            3'd0:    digit_val = sec_ones;
            3'd1:    digit_val = sec_tens;
            3'd2:    begin digit_val = min_ones; is_min = 1'b1; end
            3'd3:    begin digit_val = min_tens; is_min = 1'b1; end
            3'd4:    begin digit_val = hr_ones;  is_hr  = 1'b1; end
            3'd5:    begin digit_val = hr_tens;  is_hr  = 1'b1; end
            default: digit_val = '0;
        endcase
        dp_pos  = (pos == 3'd4) || (SIX && pos == 3'd2);
        blank   = !blink_on &&
                  ((mode == MODE_SET_HR && is_hr) || (mode == MODE_SET_MIN && is_min));
        seg_ah  = {dp_pos && (blink_on || mode != MODE_RUN),
                   blank ? 7'b0000000 : glyph(digit_val)};
        dsel_ah = DW'(1) << idx_d;
        seg_d   = ACTIVE_LOW ? ~seg_ah : seg_ah;
        dsel_d  = ACTIVE_LOW ? ~dsel_ah : dsel_ah;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_RST;
            dsel_q     <= DSEL_RST;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dsel_q     <= dsel_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.digit_sel = dsel_q;
    assign bus.hours     = hours_q;
    assign bus.minutes   = minutes_q;
    assign bus.seconds   = seconds_q;
    assign bus.sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_rtc_display_mux.sv
// Bench for rtc_display_mux: a 6-digit active-low and a 4-digit active-high
// instance share stimulus and are compared every cycle against a time-of-day model.
module tb_rtc_display_mux;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_en, inc, clr_sec;
    logic [1:0] set_mode;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: time as seconds-of-day plus divider counts.
    int         tod, presc, scan_cnt, idx6, idx4;
    logic       tick_exp;
    logic [7:0] seg6_exp, seg4_exp;
    logic [5:0] dsel6_exp;
    logic [3:0] dsel4_exp;

    always #5 clk = ~clk;

    rtc_display_mux_if #(.NUM_DIGITS(6)) bus6 ();
    rtc_display_mux_if #(.NUM_DIGITS(4)) bus4 ();

    assign bus6.run_en   = run_en;
    assign bus6.set_mode = set_mode;
    assign bus6.inc      = inc;
    assign bus6.clr_sec  = clr_sec;
    assign bus4.run_en   = run_en;
    assign bus4.set_mode = set_mode;
    assign bus4.inc      = inc;
    assign bus4.clr_sec  = clr_sec;

    rtc_display_mux #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                      .NUM_DIGITS(6), .ACTIVE_LOW(1'b1)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    rtc_display_mux #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                      .NUM_DIGITS(4), .ACTIVE_LOW(1'b0)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-high segment pattern for digit idx of an n-digit display.
    function automatic logic [7:0] disp(input int idx, input int n, input int mode);
        int h, m, s, val, field;
        int v6[6], v4[4], f6[6], f4[4];
        bit blink_on, dp, blank;
        h  = tod / 3600;
        m  = (tod / 60) % 60;
        s  = tod % 60;
        v6 = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
        v4 = '{m % 10, m / 10, h % 10, h / 10};
        f6 = '{0, 0, 1, 1, 2, 2};
        f4 = '{1, 1, 2, 2};
        blink_on = (presc < TICK_DIV / 2);
        if (n == 6) begin
            val = v6[idx]; field = f6[idx]; dp = (idx == 2 || idx == 4);
        end else begin
            val = v4[idx]; field = f4[idx]; dp = (idx == 2);
        end
        dp    = dp && (mode != 0 || blink_on);
        blank = !blink_on && ((mode == 1 && field == 2) || (mode == 2 && field == 1));
        return {dp, blank ? 7'h00 : GLYPH[val]};
    endfunction

    task automatic model_reset();
        tod = 0; presc = 0; scan_cnt = 0; idx6 = 0; idx4 = 0;
        tick_exp  = 1'b0;
        seg6_exp  = 8'hC0;
        dsel6_exp = 6'b111110;
        seg4_exp  = 8'h3F;
        dsel4_exp = 4'b0001;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int mode, h, m, s;
        bit wrap, swrap;
        mode  = (set_mode == 2'b01) ? 1 : (set_mode == 2'b10) ? 2 : 0;
        wrap  = run_en && (presc == TICK_DIV - 1);
        swrap = (scan_cnt == SCAN_DIV - 1);
        if (swrap) begin
            idx6 = (idx6 + 1) % 6;
            idx4 = (idx4 + 1) % 4;
        end
        seg6_exp  = ~disp(idx6, 6, mode);
        dsel6_exp = ~6'(1 << idx6);
        seg4_exp  = disp(idx4, 4, mode);
        dsel4_exp = 4'(1 << idx4);
        scan_cnt  = swrap ? 0 : scan_cnt + 1;
        tick_exp  = wrap;
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        if (mode == 0) begin
            if (clr_sec)   tod = tod - s;
            else if (wrap) tod = (tod + 1) % 86400;
        end else begin
            if (inc && mode == 1) h = (h + 1) % 24;
            if (inc && mode == 2) m = (m + 1) % 60;
            if (clr_sec) s = 0;
            tod = h * 3600 + m * 60 + s;
        end
        if (clr_sec || wrap) presc = 0;
        else if (run_en)     presc = presc + 1;
    endtask

    task automatic check_all();
        chk("hours",    32'(bus6.hours),     32'(tod / 3600));
        chk("minutes",  32'(bus6.minutes),   32'((tod / 60) % 60));
        chk("seconds",  32'(bus6.seconds),   32'(tod % 60));
        chk("sec_tick", 32'(bus6.sec_tick),  32'(tick_exp));
        chk("seg6",     32'(bus6.seg),       32'(seg6_exp));
        chk("dsel6",    32'(bus6.digit_sel), 32'(dsel6_exp));
        chk("hours4",   32'(bus4.hours),     32'(tod / 3600));
        chk("minutes4", 32'(bus4.minutes),   32'((tod / 60) % 60));
        chk("seg4",     32'(bus4.seg),       32'(seg4_exp));
        chk("dsel4",    32'(bus4.digit_sel), 32'(dsel4_exp));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_seg6"},  32'(bus6.seg),       32'h0000_00C0);
        chk({tag, "_dsel6"}, 32'(bus6.digit_sel), 32'h0000_003E);
        chk({tag, "_seg4"},  32'(bus4.seg),       32'h0000_003F);
        chk({tag, "_dsel4"}, 32'(bus4.digit_sel), 32'h0000_0001);
        chk({tag, "_time"},  32'({bus6.hours, bus6.minutes, bus6.seconds}), 32'h0);
        chk({tag, "_tick"},  32'(bus6.sec_tick),  32'h0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        step();
        inc = 1'b0;
    endtask

    initial begin
        int         cyc;
        int         min_before;
        logic [7:0] exp_seg;
        logic [5:0] exp_sel;

        run_en = 1'b0; set_mode = 2'b00; inc = 1'b0; clr_sec = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        check_all();

        // Free run: one tick every TICK_DIV clocks, 60 ticks carry to minutes.
        @(negedge clk);
        rst    = 1'b1;
        run_en = 1'b1;
        repeat (60 * TICK_DIV) step();
        chk("after60_sec", 32'(bus6.seconds), 32'd0);
        chk("after60_min", 32'(bus6.minutes), 32'd1);

        // 59 more ticks, then preload 23:59 in set mode and roll over.
        repeat (59 * TICK_DIV) step();
        set_mode = 2'b01;
        cyc = 0;
        while (tod / 3600 != 23 && cyc < 30) begin pulse_inc(); cyc++; end
        chk("set_hr_23", 32'(bus6.hours), 32'd23);
        set_mode = 2'b10;
        cyc = 0;
        while ((tod / 60) % 60 != 59 && cyc < 70) begin pulse_inc(); cyc++; end
        chk("set_min_59", 32'(bus6.minutes), 32'd59);
        set_mode = 2'b00;
        cyc = 0;
        while (presc != TICK_DIV - 1 && cyc < 2 * TICK_DIV) begin step(); cyc++; end
        chk("pre_roll", 32'({bus6.hours, bus6.minutes, bus6.seconds}),
            32'({5'd23, 6'd59, 6'd59}));
        step();
        chk("roll_time", 32'({bus6.hours, bus6.minutes, bus6.seconds}), 32'd0);
        chk("roll_tick", 32'(bus6.sec_tick), 32'd1);

        // Hours 23 -> 0 by inc without carry, then frozen with blinking hours.
        set_mode = 2'b01;
        cyc = 0;
        while (tod / 3600 != 23 && cyc < 30) begin pulse_inc(); cyc++; end
        chk("hr_23_again", 32'(bus6.hours), 32'd23);
        pulse_inc();
        chk("hr_wrap", 32'(bus6.hours), 32'd0);
        chk("hr_wrap_min", 32'(bus6.minutes), 32'd0);
        repeat (6 * TICK_DIV) step();
        chk("frozen", 32'({bus6.hours, bus6.minutes, bus6.seconds}), 32'd0);

        // clr_sec together with inc in minute set mode.
        set_mode = 2'b10;
        inc = 1'b1; clr_sec = 1'b1;
        step();
        inc = 1'b0; clr_sec = 1'b0;
        chk("clr_inc_min", 32'(bus6.minutes), 32'd1);
        chk("clr_inc_sec", 32'(bus6.seconds), 32'd0);

        // clr_sec on the same cycle as a tick at seconds=59.
        set_mode = 2'b00;
        cyc = 0;
        while (!(tod % 60 == 59 && presc == TICK_DIV - 1) && cyc < 70 * TICK_DIV) begin
            step(); cyc++;
        end
        chk("pre_clr_sec", 32'(bus6.seconds), 32'd59);
        min_before = (tod / 60) % 60;
        clr_sec = 1'b1;
        step();
        clr_sec = 1'b0;
        chk("clr_sec_sec", 32'(bus6.seconds), 32'd0);
        chk("clr_sec_min", 32'(bus6.minutes), 32'(min_before));
        repeat (TICK_DIV - 1) step();
        chk("clr_presc_quiet", 32'(bus6.sec_tick), 32'd0);
        step();
        chk("clr_presc_tick", 32'(bus6.sec_tick), 32'd1);

        // Set 12:34, run to :56, then pause and watch the scan.
        set_mode = 2'b01;
        cyc = 0;
        while (tod / 3600 != 12 && cyc < 30) begin pulse_inc(); cyc++; end
        set_mode = 2'b10;
        cyc = 0;
        while ((tod / 60) % 60 != 34 && cyc < 70) begin pulse_inc(); cyc++; end
        set_mode = 2'b00;
        cyc = 0;
        while (tod % 60 != 56 && cyc < 70 * TICK_DIV) begin step(); cyc++; end
        run_en = 1'b0;
        repeat (100) step();
        chk("pause_time", 32'({bus6.hours, bus6.minutes, bus6.seconds}),
            32'({5'd12, 6'd34, 6'd56}));
        cyc = 0;
        while (!(idx6 == 0 && scan_cnt == 0) && cyc < 20) begin step(); cyc++; end
        for (int k = 0; k < 6; k++) begin
            exp_sel = ~6'(1 << k);
            exp_seg = ~{(k == 2 || k == 4), GLYPH[6 - k]};
            chk("scan_sel", 32'(bus6.digit_sel), 32'(exp_sel));
            chk("scan_seg", 32'(bus6.seg), 32'(exp_seg));
            step();
            chk("scan_hold_seg", 32'(bus6.seg), 32'(exp_seg));
            step();
        end

        // Asynchronous reset mid-scan takes effect without a clock edge.
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst    = 1'b1;
        run_en = 1'b1;
        repeat (3 * TICK_DIV) step();

        // Randomized controls against the model.
        for (int i = 0; i < 2000; i++) begin
            run_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) set_mode = 2'($urandom_range(0, 3));
            inc     = ($urandom_range(0, 3) == 0);
            clr_sec = ($urandom_range(0, 31) == 0);
            step();
        end
        inc = 1'b0; clr_sec = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rtc_display_mux.md
Name: rtc_display_mux

Overview:
- Parametrised real-time clock with a multiplexed 7-segment display driver.
- Keeps HH:MM:SS time from a divided system clock and scans 4 or 6 common-anode or common-cathode digits.
- Supports run/pause and a set mode for hours and minutes, with the field being set blinking.
- Sits between board clock, buttons (already debounced, single-cycle pulses) and the display pins.

Parameters:
- TICK_DIV, 50000000, clk cycles per second tick (>=4).
- SCAN_DIV, 50000, clk cycles per digit scan step (>=2).
- NUM_DIGITS, 6, 6 = HH MM SS; 4 = HH MM. Other values are illegal and must fail elaboration.
- ACTIVE_LOW, 1, 1 = seg and digit_sel are driven active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- run_en  in  1  1 = time advances; 0 = paused.
- set_mode  in  2  00 run, 01 set hours, 10 set minutes, 11 treated as 00.
- inc  in  1  single-cycle pulse; increments the selected field in set mode.
- clr_sec  in  1  single-cycle pulse; seconds and prescaler go to 0.
- seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- digit_sel  out  NUM_DIGITS  one-hot digit enable; bit 0 = rightmost digit.
- hours  out  5  0..23, binary.
- minutes  out  6  0..59, binary.
- seconds  out  6  0..59, binary.
- sec_tick  out  1  one-cycle pulse per prescaler wrap.

Behaviour:
- Reset: asynchronous, active-low rst; clock clk.
  - All counters, hours, minutes, seconds and sec_tick go to 0; scan index goes to 0.
  - digit_sel selects digit 0; seg shows glyph '0' with dp off.
- Prescaler:
  - Counts 0..TICK_DIV-1 whenever run_en=1, including in set mode. It holds when run_en=0.
  - sec_tick=1 in the cycle after the count reaches TICK_DIV-1, and the count wraps to 0.
  - blink_on = (prescaler < TICK_DIV/2).
- Timekeeping (set_mode=00, run_en=1, on each tick):
  - seconds increments; 59 wraps to 0 and carries to minutes.
  - minutes 59 wraps to 0 and carries to hours.
  - hours 23 wraps to 0.
  - 23:59:59 + tick = 00:00:00 in one cycle.
- Set mode (01 or 10):
  - Ticks do not change hours, minutes or seconds.
  - inc adds 1 to the selected field only, with no carry: hours 23->0, minutes 59->0.
  - inc is ignored in run mode.
- clr_sec:
  - Clears seconds and the prescaler in any mode.
  - If clr_sec and a tick occur in the same cycle, clr_sec wins and no carry is produced.
  - If clr_sec and inc occur in the same cycle, both take effect.
- Mode exit: returning to 00 resumes counting from the current prescaler value; no catch-up.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 continuously. It is not gated by run_en.
  - On wrap, the digit index advances (0..NUM_DIGITS-1, then back to 0).
  - seg and digit_sel are registered together from the new index, so they always refer to the same digit with no skew cycle.
- Digit mapping (6 digits), index 0..5 = sec ones, sec tens, min ones, min tens, hr ones, hr tens.
  - With NUM_DIGITS=4: 0..3 = min ones, min tens, hr ones, hr tens.
  - BCD comes from binary by /10 and %10 on 6-bit values, computed combinationally before the output register.
- Glyphs: standard gfedcba for 0..9 (0=0111111 active-high).
- Decimal point:
  - dp is lit on the digits at index 2 and 4 (6-digit) or index 2 (4-digit) when blink_on=1.
  - In set mode dp is lit steadily.
- Blink: in set mode, both digits of the selected field are blanked (all segments off) when blink_on=0.
- Polarity: with ACTIVE_LOW=1, seg and digit_sel are the bitwise inverse of the active-high values, including reset values.
- Reset mid-operation: the next posedge after rst deasserts starts from the full reset state; there is no partial retention.

Test Plan:
- TICK_DIV=4, SCAN_DIV=2, reset then run_en=1:
  - sec_tick pulses every 4 clk.
  - After 60 ticks: seconds=0, minutes=1.
- Preload to 23:59:59 via set mode plus inc pulses (hours 23, minutes 59), with 59 ticks run before entering set mode:
  - The next tick yields 00:00:00 with no intermediate value.
- set_mode=01 at hours=23, one inc:
  - hours=0, minutes unchanged.
  - Ticks leave time frozen.
  - Hour digits blank on alternate half-seconds; dp steady.
- clr_sec asserted in the same cycle as a tick at seconds=59:
  - seconds=0, minutes unchanged, prescaler=0.
- Scan check, NUM_DIGITS=6, ACTIVE_LOW=1, time 12:34:56:
  - digit_sel cycles 111110, 111101, 111011, 110111, 101111, 011111.
  - seg shows inverted glyphs 6,5,4,3,2,1, changing only on scan wrap.
- run_en=0 for 100 clk, then asynchronous rst pulsed mid-scan:
  - Time holds during the pause; scan continues.
  - On reset, outputs go immediately to the reset values.
  - NUM_DIGITS=4 variant shows minutes on digits 0-1.
